// File: rtl/synth_regs_pkg.sv
// Shared register map, field widths and handshake state encoding for the synth
// parameter transfer path.
package synth_regs_pkg;

  localparam int unsigned FCW_W   = 24;
  localparam int unsigned SHIFT_W = 5;

  localparam int unsigned SYNTH_ADDR_MOD_FCW     = 'h20;
  localparam int unsigned SYNTH_ADDR_MOD_SHIFT   = 'h21;
  localparam int unsigned SYNTH_ADDR_SYNTH_SHIFT = 'h22;
  localparam int unsigned SYNTH_ADDR_NOTE_EN     = 'h23;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RELEASE
  } tx_state_e;

endpackage

// File: rtl/synth_param_tx_if.sv
// MMIO write port plus the req/ack snapshot bus between the CPU-side initiator
// and the synth-side receiver.
interface synth_param_tx_if
  import synth_regs_pkg::*;
#(
  parameter int unsigned N_VOICES = 1,
  parameter int unsigned ADDR_W   = 6
);

  logic                      wr_en;
  logic [ADDR_W-1:0]         wr_addr;
  logic [31:0]               wr_data;
  logic [FCW_W*N_VOICES-1:0] cpu_carrier_fcws;
  logic [FCW_W-1:0]          cpu_mod_fcw;
  logic [SHIFT_W-1:0]        cpu_mod_shift;
  logic [N_VOICES-1:0]       cpu_note_en;
  logic [SHIFT_W-1:0]        cpu_synth_shift;
  logic                      cpu_req;
  logic                      cpu_ack;
  logic                      busy;
  logic                      pending;

  modport master (
    input  wr_en, wr_addr, wr_data, cpu_ack,
    output cpu_carrier_fcws, cpu_mod_fcw, cpu_mod_shift, cpu_note_en, cpu_synth_shift,
    output cpu_req, busy, pending
  );

  modport slave (
    output wr_en, wr_addr, wr_data, cpu_ack,
    input  cpu_carrier_fcws, cpu_mod_fcw, cpu_mod_shift, cpu_note_en, cpu_synth_shift,
    input  cpu_req, busy, pending
  );

endinterface

// File: rtl/req_ack_tx.sv
// Four-phase request/acknowledge initiator FSM; load pulses on the launch edge so
// the parent can freeze its snapshot.
module req_ack_tx
  import synth_regs_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic cpu_ack,
  output logic cpu_req,
  output logic busy,
  output logic load
);

  tx_state_e state_q;

  // Never launch while ack is still high, so a stale ack cannot finish a new transfer.
  assign load = (state_q == IDLE) && start && !cpu_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cpu_req <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load) begin
            state_q <= REQ;
            cpu_req <= 1'b1;
            busy    <= 1'b1;
          end
        end
        REQ: begin
          if (cpu_ack) begin
            state_q <= RELEASE;
            cpu_req <= 1'b0;
          end
        end
        RELEASE: begin
          if (!cpu_ack) begin
            state_q <= IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          cpu_req <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/synth_param_tx.sv
// CPU-side parameter initiator: MMIO decode into shadow registers, snapshot on
// launch, one req/ack transfer at a time.
module synth_param_tx
  import synth_regs_pkg::*;
#(
  parameter int unsigned N_VOICES = 1,
  parameter int unsigned ADDR_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  synth_param_tx_if.master  bus
);

  logic [N_VOICES-1:0]            wr_carrier;
  logic                           wr_mod_fcw, wr_mod_shift, wr_synth_shift, wr_note_en;
  logic                           wr_valid;
  logic                           load;
  logic                           pending_q;

  logic [N_VOICES-1:0][FCW_W-1:0] carrier_q, carrier_snap_q;
  logic [FCW_W-1:0]               mod_fcw_q, mod_fcw_snap_q;
  logic [SHIFT_W-1:0]             mod_shift_q, mod_shift_snap_q;
  logic [SHIFT_W-1:0]             synth_shift_q, synth_shift_snap_q;
  logic [N_VOICES-1:0]            note_en_q, note_en_snap_q;

  logic unused_wr_data;
  assign unused_wr_data = ^bus.wr_data[31:FCW_W];

  always_comb begin
    wr_carrier = '0;
    for (int i = 0; i < int'(N_VOICES); i++) begin
      wr_carrier[i] = bus.wr_en && (bus.wr_addr == ADDR_W'(i));
    end
    wr_mod_fcw     = bus.wr_en && (bus.wr_addr == ADDR_W'(SYNTH_ADDR_MOD_FCW));
    wr_mod_shift   = bus.wr_en && (bus.wr_addr == ADDR_W'(SYNTH_ADDR_MOD_SHIFT));
    wr_synth_shift = bus.wr_en && (bus.wr_addr == ADDR_W'(SYNTH_ADDR_SYNTH_SHIFT));
    wr_note_en     = bus.wr_en && (bus.wr_addr == ADDR_W'(SYNTH_ADDR_NOTE_EN));
    wr_valid       = (|wr_carrier) | wr_mod_fcw | wr_mod_shift | wr_synth_shift | wr_note_en;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carrier_q     <= '0;
      mod_fcw_q     <= '0;
      mod_shift_q   <= '0;
      synth_shift_q <= '0;
      note_en_q     <= '0;
    end else begin
      for (int i = 0; i < int'(N_VOICES); i++) begin
        if (wr_carrier[i]) carrier_q[i] <= bus.wr_data[FCW_W-1:0];
      end
      if (wr_mod_fcw)     mod_fcw_q     <= bus.wr_data[FCW_W-1:0];
      if (wr_mod_shift)   mod_shift_q   <= bus.wr_data[SHIFT_W-1:0];
      if (wr_synth_shift) synth_shift_q <= bus.wr_data[SHIFT_W-1:0];
      if (wr_note_en)     note_en_q     <= bus.wr_data[N_VOICES-1:0];
    end
  end

  // A write on the launch edge wins over the clear so it rides the next transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= 1'b0;
    end else if (wr_valid) begin
      pending_q <= 1'b1;
    end else if (load) begin
      pending_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carrier_snap_q     <= '0;
      mod_fcw_snap_q     <= '0;
      mod_shift_snap_q   <= '0;
      synth_shift_snap_q <= '0;
      note_en_snap_q     <= '0;
    end else if (load) begin
      carrier_snap_q     <= carrier_q;
      mod_fcw_snap_q     <= mod_fcw_q;
      mod_shift_snap_q   <= mod_shift_q;
      synth_shift_snap_q <= synth_shift_q;
      note_en_snap_q     <= note_en_q;
    end
  end

  req_ack_tx u_req_ack_tx (
    .clk     (clk),
    .rst     (rst),
    .start   (pending_q),
    .cpu_ack (bus.cpu_ack),
    .cpu_req (bus.cpu_req),
    .busy    (bus.busy),
    .load    (load)
  );

  assign bus.cpu_carrier_fcws = carrier_snap_q;
  assign bus.cpu_mod_fcw      = mod_fcw_snap_q;
  assign bus.cpu_mod_shift    = mod_shift_snap_q;
  assign bus.cpu_synth_shift  = synth_shift_snap_q;
  assign bus.cpu_note_en      = note_en_snap_q;
  assign bus.pending          = pending_q;

endmodule

// File: tb/tb_synth_param_tx.sv
// Scoreboard bench for synth_param_tx with four voices; expected snapshots come
// from a shadow-register model updated by the write task.
module tb_synth_param_tx;

  typedef struct packed {
    logic [95:0] carrier;
    logic [23:0] mod_fcw;
    logic [4:0]  mod_shift;
    logic [4:0]  synth_shift;
    logic [3:0]  note_en;
  } snap_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   ok;
  int   seen;
  snap_t exp_q[$];
  snap_t old;

  logic [23:0] m_car [4];
  logic [23:0] m_fcw;
  logic [4:0]  m_mshift, m_sshift;
  logic [3:0]  m_nen;

  always #5 clk = ~clk;

  synth_param_tx_if #(.N_VOICES(4), .ADDR_W(6)) bus ();

  synth_param_tx #(.N_VOICES(4), .ADDR_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic snap_t snap();
    return {bus.cpu_carrier_fcws, bus.cpu_mod_fcw, bus.cpu_mod_shift,
            bus.cpu_synth_shift, bus.cpu_note_en};
  endfunction

  function automatic snap_t model_snap();
    return {m_car[3], m_car[2], m_car[1], m_car[0], m_fcw, m_mshift, m_sshift, m_nen};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_car[i] = '0;
    m_fcw = '0; m_mshift = '0; m_sshift = '0; m_nen = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    if (a < 6'd4) m_car[a[1:0]] = d[23:0];
    else if (a == 6'h20) m_fcw = d[23:0];
    else if (a == 6'h21) m_mshift = d[4:0];
    else if (a == 6'h22) m_sshift = d[4:0];
    else if (a == 6'h23) m_nen = d[3:0];
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_req(output bit got);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.cpu_req) begin got = 1'b1; break; end
      step();
    end
  endtask

  // Completes the current transfer; got=0 if either handshake phase times out.
  task automatic finish_xfer(input int dly, output bit got);
    got = 1'b0;
    repeat (dly) step();
    bus.cpu_ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!bus.cpu_req) begin got = 1'b1; break; end
    end
    bus.cpu_ack = 1'b0;
    if (got) begin
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
        step();
        if (!bus.busy) begin got = 1'b1; break; end
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.cpu_req, bus.busy, bus.pending} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b exp 000", {bus.cpu_req, bus.busy, bus.pending});
    end
    checks++;
    if (snap() !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", snap()); end
    wr(6'h20, 32'h0011_1111);
    step();
    rst = 1'b1;
    #1;
    model_clear();
    checks++;
    if ({bus.cpu_req, bus.busy, bus.pending} !== 3'b000 || snap() !== '0) begin
      errors++; $display("FAIL mid_req_reset got req %b data %h exp 0", bus.cpu_req, snap());
    end
    bus.cpu_ack = 1'b1;
    step();
    rst = 1'b0;
    seen = 0;
    repeat (5) begin step(); if (bus.cpu_req) seen++; end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL stale_ack_req got %0d exp 0", seen); end
    wr(6'h21, 32'h5);
    repeat (3) step();
    checks++;
    if ({bus.cpu_req, bus.pending} !== 2'b01) begin
      errors++; $display("FAIL ack_high_hold got %b exp 01", {bus.cpu_req, bus.pending});
    end
    bus.cpu_ack = 1'b0;
    exp_q.push_back(model_snap());
    step();
    checks++;
    if (!bus.cpu_req || snap() !== exp_q[0]) begin
      errors++; $display("FAIL after_ack_drop got req %b %h exp 1 %h", bus.cpu_req, snap(), exp_q[0]);
    end
    void'(exp_q.pop_front());
    finish_xfer(2, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL xfer_timeout_r1 got 0 exp 1"); end
    wr(6'h20, 32'h0012_3456);
    exp_q.push_back(model_snap());
    checks++;
    if (bus.cpu_req !== 1'b0) begin errors++; $display("FAIL req_early got 1 exp 0"); end
    step();
    checks++;
    if (!bus.cpu_req || bus.cpu_mod_fcw !== 24'h123456 || snap() !== exp_q[0]) begin
      errors++; $display("FAIL post_reset_xfer got req %b %h exp 1 %h", bus.cpu_req, snap(), exp_q[0]);
    end
    void'(exp_q.pop_front());
    finish_xfer(1, ok);
  endtask

  task automatic test_single();
    wr(6'd2, 32'h00AB_CDEF);
    exp_q.push_back(model_snap());
    step();
    checks++;
    if (!bus.cpu_req || snap() !== exp_q[0] || bus.cpu_carrier_fcws[71:48] !== 24'hABCDEF) begin
      errors++; $display("FAIL single_snapshot got req %b %h exp 1 %h", bus.cpu_req, snap(), exp_q[0]);
    end
    void'(exp_q.pop_front());
    repeat (3) step();
    bus.cpu_ack = 1'b1;
    step();
    checks++;
    if ({bus.cpu_req, bus.busy} !== 2'b01) begin
      errors++; $display("FAIL single_release got %b exp 01", {bus.cpu_req, bus.busy});
    end
    bus.cpu_ack = 1'b0;
    step();
    checks++;
    if ({bus.busy, bus.pending} !== 2'b00) begin
      errors++; $display("FAIL single_idle got %b exp 00", {bus.busy, bus.pending});
    end
  endtask

  task automatic test_coalesce();
    wr(6'h21, 32'h2);
    exp_q.push_back(model_snap());
    wait_req(ok);
    checks++;
    if (!ok || snap() !== exp_q[0]) begin
      errors++; $display("FAIL coal_first got %h exp %h", snap(), exp_q[0]);
    end
    old = exp_q.pop_front();
    wr(6'h21, 32'h3);
    wr(6'h21, 32'h7);
    checks++;
    if (!bus.cpu_req || snap() !== old) begin
      errors++; $display("FAIL coal_hold_req got %h exp %h", snap(), old);
    end
    bus.cpu_ack = 1'b1;
    step();
    checks++;
    if (bus.cpu_req || snap() !== old) begin
      errors++; $display("FAIL coal_hold_rel got req %b %h exp 0 %h", bus.cpu_req, snap(), old);
    end
    bus.cpu_ack = 1'b0;
    exp_q.push_back(model_snap());
    step();
    checks++;
    if ({bus.busy, bus.pending, bus.cpu_req} !== 3'b010) begin
      errors++; $display("FAIL coal_idle got %b exp 010", {bus.busy, bus.pending, bus.cpu_req});
    end
    step();
    checks++;
    if (!bus.cpu_req || bus.cpu_mod_shift !== 5'd7 || snap() !== exp_q[0]) begin
      errors++; $display("FAIL coal_second got req %b %h exp 1 %h", bus.cpu_req, snap(), exp_q[0]);
    end
    void'(exp_q.pop_front());
    finish_xfer(2, ok);
    seen = 0;
    repeat (5) begin step(); if (bus.cpu_req) seen++; end
    checks++;
    if (!ok || seen !== 0 || bus.pending !== 1'b0) begin
      errors++; $display("FAIL coal_extra got ok %b reqs %0d exp 1 0", ok, seen);
    end
  endtask

  task automatic test_collision();
    wr(6'h20, 32'h00AA_AAAA);
    exp_q.push_back(model_snap());
    wr(6'h22, 32'h9);
    checks++;
    if (!bus.cpu_req || !bus.pending || snap() !== exp_q[0]) begin
      errors++; $display("FAIL coll_launch got req %b pend %b %h exp 1 1 %h",
                         bus.cpu_req, bus.pending, snap(), exp_q[0]);
    end
    void'(exp_q.pop_front());
    finish_xfer(1, ok);
    exp_q.push_back(model_snap());
    step();
    checks++;
    if (!ok || !bus.cpu_req || bus.cpu_synth_shift !== 5'd9 || snap() !== exp_q[0]) begin
      errors++; $display("FAIL coll_next got req %b %h exp 1 %h", bus.cpu_req, snap(), exp_q[0]);
    end
    void'(exp_q.pop_front());
    finish_xfer(1, ok);
  endtask

  task automatic test_invalid();
    wr(6'h10, 32'hFFFF_FFFF);
    wr(6'h04, 32'hFFFF_FFFF);
    checks++;
    if (bus.pending !== 1'b0) begin errors++; $display("FAIL inv_pending got 1 exp 0"); end
    seen = 0;
    repeat (3) begin step(); if (bus.cpu_req) seen++; end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL inv_req got %0d exp 0", seen); end
    wr(6'h23, 32'hFFFF_FFFF);
    exp_q.push_back(model_snap());
    step();
    checks++;
    if (!bus.cpu_req || bus.cpu_note_en !== 4'hF || snap() !== exp_q[0]) begin
      errors++; $display("FAIL note_en got req %b %h exp 1 %h", bus.cpu_req, snap(), exp_q[0]);
    end
    void'(exp_q.pop_front());
    finish_xfer(1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL xfer_timeout_inv got 0 exp 1"); end
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.cpu_ack = 1'b0;
    model_clear();
    repeat (2) step();
    rst = 1'b0;
    step();
    test_reset();
    test_single();
    test_coalesce();
    test_collision();
    test_invalid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/synth_param_tx.md
# synth_param_tx

CPU-domain initiator for the four-phase req/ack parameter transfer into the synth clock domain. It captures memory-mapped CPU writes of synth parameters into shadow registers, then launches one transfer at a time: it freezes a snapshot on the `cpu_*` bus, raises `cpu_req`, and waits for `cpu_ack` to rise and fall. It sits between the CPU MMIO decode and the synth-side CDC receiver, which returns `cpu_ack` already synchronized to `clk`.

## Interface
- `N_VOICES`, default 1: number of carrier voices; legal range 1–32.
- `ADDR_W`, default 6: width of the write word address.

- `clk`  in  1  CPU clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  MMIO write strobe; one write per cycle.
- `wr_addr`  in  ADDR_W  word address of the write.
- `wr_data`  in  32  write data.
- `cpu_carrier_fcws`  out  24*N_VOICES  snapshot of the carrier FCWs; voice i occupies bits [24i+23:24i].
- `cpu_mod_fcw`  out  24  snapshot of the modulator FCW.
- `cpu_mod_shift`  out  5  snapshot of the modulator shift.
- `cpu_note_en`  out  N_VOICES  snapshot of the per-voice note enables.
- `cpu_synth_shift`  out  5  snapshot of the synth output shift.
- `cpu_req`  out  1  transfer request to the receiver.
- `cpu_ack`  in  1  acknowledge from the receiver, already synchronized to `clk`.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `pending`  out  1  shadow registers hold changes not yet snapshotted.

## Operation
Address map (word addresses); writes to any other address are ignored and do not set `pending`:
- `0 .. N_VOICES-1`: carrier FCW of voice i, taken from `wr_data[23:0]`.
- `0x20`: `mod_fcw`, from `wr_data[23:0]`.
- `0x21`: `mod_shift`, from `wr_data[4:0]`.
- `0x22`: `synth_shift`, from `wr_data[4:0]`.
- `0x23`: `note_en`, from `wr_data[N_VOICES-1:0]`.
- Upper data bits are ignored.

A valid write updates its shadow register and sets `pending` on the same edge.

FSM states:
- **IDLE**, `cpu_req`=0.
  - If `pending`=1 and `cpu_ack`=0: go to REQ.
  - On that edge, copy all shadows to the `cpu_*` outputs.
  - On that edge, `pending` is set to 1 if a valid write occurs in the same cycle, otherwise cleared to 0. The write lands in the shadow after the snapshot, so it is carried by the next transfer.
- **REQ**, `cpu_req`=1.
  - When `cpu_ack`=1: go to RELEASE.
- **RELEASE**, `cpu_req`=0.
  - When `cpu_ack`=0: go to IDLE.

Data stability rule: the `cpu_*` data outputs change only on the IDLE→REQ edge. They stay constant from the first cycle `cpu_req` is high until `cpu_ack` has returned low.

Writes are accepted in every state and never stall. Multiple writes during one transfer coalesce into a single follow-up transfer, with the last value per register winning.

## Timing
- `cpu_req` and `busy` come directly from registers.
- Reset values:
  - `cpu_req`=0, `busy`=0, `pending`=0, state IDLE.
  - All `cpu_*` data outputs and all shadow registers are 0.
- Latency:
  - Write sampled at edge 0 → `pending`=1 after edge 0.
  - Edge 1 → `cpu_req`=1 with the new snapshot.
  - Total: one cycle from write to request.
- Transfer length: 2 cycles of FSM overhead plus the receiver's ack round-trip, in both phases.
- IDLE is held for at least one cycle between transfers. The back-to-back minimum period is RELEASE exit → IDLE → REQ, i.e. one IDLE cycle.
- Reset mid-transfer:
  - `cpu_req` drops asynchronously and `pending` clears.
  - A new request is not raised until `cpu_ack` reads 0 in IDLE. This guarantees that no stale ack completes a new transfer.
- `cpu_ack` high in IDLE (e.g. after reset): the FSM stays in IDLE and `pending` is held.

## Structure
- Shared package `synth_regs_pkg` holds:
  - the address constants `SYNTH_ADDR_MOD_FCW`=0x20, `SYNTH_ADDR_MOD_SHIFT`=0x21, `SYNTH_ADDR_SYNTH_SHIFT`=0x22, `SYNTH_ADDR_NOTE_EN`=0x23;
  - the field widths FCW_W=24 and SHIFT_W=5;
  - the state encoding IDLE/REQ/RELEASE.
- One natural sub-module, `req_ack_tx`:
  - contains the three-state FSM;
  - inputs `start` and `cpu_ack`; outputs `cpu_req`, `busy` and a one-cycle `load` pulse on the IDLE→REQ edge.
- The top level holds the address decode, the shadow registers and the snapshot registers.

## Test plan
- **Reset:** assert `rst` mid-REQ → `cpu_req`=0 immediately and all outputs are 0. Keep `cpu_ack`=1 for 5 cycles after release → no request is raised. Drop ack and write 0x20=0x123456 → `cpu_req` rises one cycle after the write, with `cpu_mod_fcw`=0x123456.
- **Single transfer:** with N_VOICES=4, write addr 2=0xABCDEF → `cpu_carrier_fcws[71:48]`=0xABCDEF when `cpu_req` rises. Drive ack high 3 cycles later → `cpu_req` falls. Drive ack low → `busy`=0 and `pending`=0.
- **Coalescing:** while in REQ, write 0x21=3 then 0x21=7 → the outputs hold their old values until ack falls. Exactly one extra transfer follows, with `cpu_mod_shift`=7.
- **Launch collision:** write 0x22=9 in the same cycle as the IDLE→REQ launch of an earlier write → the current snapshot excludes 9, `pending` stays 1, and the next transfer has `cpu_synth_shift`=9.
- **Invalid address:** write addr 0x10=0xFFFFFFFF → no pending, no request. Write 0x23=0xFFFFFFFF with N_VOICES=4 → `cpu_note_en`=4'hF.
